// File: rtl/mult_div_unit.sv
// Sequential 32-bit signed multiply (radix-2 Booth) / divide (restoring) unit.
// Results land in HI/LO on the edge entering FINISH; done/div_zero pulse for one cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        mult_start,
  input  logic        div_start,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, FINISH = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] booth_q, booth_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] div_q, div_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        negq_q, negq_d, negr_q, negr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [32:0] booth_sum_s;
  logic [64:0] booth_step_s;
  logic [63:0] div_sh_s, div_step_s;
  logic [32:0] div_trial_s;
  logic [31:0] quot_s, rem_s;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  // Next-state, datapath steps and result formatting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    booth_d = booth_q;
    mcand_d = mcand_q;
    div_d   = div_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    // Accumulator is widened to 33 bits so the shift keeps the true sign when
    // subtracting the most negative multiplicand.
    case (booth_q[1:0])
      2'b01:   booth_sum_s = {booth_q[64], booth_q[64:33]} + {mcand_q[31], mcand_q};
      2'b10:   booth_sum_s = {booth_q[64], booth_q[64:33]} - {mcand_q[31], mcand_q};
      default: booth_sum_s = {booth_q[64], booth_q[64:33]};
    endcase
    booth_step_s = {booth_sum_s, booth_q[32:1]};

    div_sh_s    = {div_q[62:0], 1'b0};
    div_trial_s = {1'b0, div_sh_s[63:32]} - {1'b0, dvsr_q};
    if (div_trial_s[32]) begin
      div_step_s = div_sh_s;
    end else begin
      div_step_s = {div_trial_s[31:0], div_sh_s[31:1], 1'b1};
    end
    quot_s = negq_q ? (32'd0 - div_step_s[31:0])  : div_step_s[31:0];
    rem_s  = negr_q ? (32'd0 - div_step_s[63:32]) : div_step_s[63:32];

    case (state_q)
      IDLE: begin
        if (mult_start) begin
          booth_d = {32'd0, b_in, 1'b0};
          mcand_d = a_in;
          cnt_d   = 6'd0;
          state_d = MULT;
        end else if (div_start) begin
          if (b_in == 32'd0) begin
            state_d = FINISH;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            div_d   = {32'd0, abs32(a_in)};
            dvsr_d  = abs32(b_in);
            negq_d  = a_in[31] ^ b_in[31];
            negr_d  = a_in[31];
            cnt_d   = 6'd0;
            state_d = DIV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        booth_d = booth_step_s;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FINISH;
          hi_d    = booth_step_s[64:33];
          lo_d    = booth_step_s[32:1];
          done_d  = 1'b1;
        end else begin
          state_d = MULT;
        end
      end
      DIV: begin
        div_d = div_step_s;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = FINISH;
          hi_d    = rem_s;
          lo_d    = quot_s;
          done_d  = 1'b1;
        end else begin
          state_d = DIV;
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      booth_q <= 65'd0;
      mcand_q <= 32'd0;
      div_q   <= 64'd0;
      dvsr_q  <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      booth_q <= booth_d;
      mcand_q <= mcand_d;
      div_q   <= div_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_mult_div_unit;

  logic        clk, reset;
  logic [31:0] a_in, b_in;
  logic        mult_start, div_start;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int total = 0;
  int bad   = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .mult_start(mult_start), .div_start(div_start),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: cycles remaining until idle, pending result from plain arithmetic
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        m_done = 1'b0, m_dz = 1'b0;

  always @(posedge clk or negedge reset) begin
    logic signed [63:0] sa, sb, r;
    if (!reset) begin
      m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_dz = 1'b0;
    end else if (m_left == 0) begin
      m_done = 1'b0; m_dz = 1'b0;
      sa = 64'(signed'(a_in));
      sb = 64'(signed'(b_in));
      if (mult_start) begin
        r = sa * sb;
        p_hi = r[63:32]; p_lo = r[31:0];
        m_left = 33;
      end else if (div_start) begin
        if (b_in == 32'd0) begin
          m_left = 1; m_done = 1'b1; m_dz = 1'b1;
        end else begin
          r = sa / sb; p_lo = r[31:0];
          r = sa % sb; p_hi = r[31:0];
          m_left = 33;
        end
      end
    end else begin
      m_left = m_left - 1;
      m_dz   = 1'b0;
      m_done = (m_left == 1);
      if (m_left == 1) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("cmp_busy", {31'd0, busy}, {31'd0, m_left != 0});
    check("cmp_done", {31'd0, done}, {31'd0, m_done});
    check("cmp_dz",   {31'd0, div_zero}, {31'd0, m_dz});
    check("cmp_hi",   hi_out, m_hi);
    check("cmp_lo",   lo_out, m_lo);
  end

  // Drive a one-cycle start; returns at the negedge of cycle 1 after capture
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic ms, input logic ds);
    @(negedge clk);
    a_in = a; b_in = b; mult_start = ms; div_start = ds;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int start_cyc, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    cyc = start_cyc;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, 32'(cyc), 32'd33);
    check({name, "_hi"}, hi_out, ehi);
    check({name, "_lo"}, lo_out, elo);
    check({name, "_dz"}, {31'd0, div_zero}, 32'd0);
  endtask

  initial begin
    logic saw_done;
    reset = 1'b0; a_in = 32'd0; b_in = 32'd0; mult_start = 1'b0; div_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    #2 reset = 1'b1;

    start_op(32'd7, 32'hFFFFFFFD, 1'b1, 1'b0);
    check("mul1_busy_c1", {31'd0, busy}, 32'd1);
    wait_done("mul1", 1, 32'hFFFFFFFF, 32'hFFFFFFEB);
    check("mul1_busy_c33", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("mul1_busy_after", {31'd0, busy}, 32'd0);
    check("mul1_done_after", {31'd0, done}, 32'd0);

    start_op(32'h80000000, 32'h80000000, 1'b1, 1'b0);
    wait_done("mul_ext", 1, 32'h40000000, 32'h00000000);

    start_op(32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    wait_done("div_neg", 1, 32'hFFFFFFFF, 32'hFFFFFFFD);

    start_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_done("div_ovf", 1, 32'h00000000, 32'h80000000);

    start_op(32'h00000451, 32'h00000020, 1'b0, 1'b1);
    wait_done("preload", 1, 32'h00000011, 32'h00000022);
    start_op(32'd5, 32'd0, 1'b0, 1'b1);
    check("dz_done", {31'd0, done}, 32'd1);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_hi", hi_out, 32'h11);
    check("dz_lo", lo_out, 32'h22);
    check("dz_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("dz_busy_drop", {31'd0, busy}, 32'd0);
    check("dz_flag_drop", {31'd0, div_zero}, 32'd0);

    start_op(32'd6, 32'd5, 1'b1, 1'b1);
    wait_done("both", 1, 32'd0, 32'd30);

    start_op(32'd3, 32'd4, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    a_in = 32'd100; b_in = 32'd7; mult_start = 1'b1; div_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0;
    wait_done("ign_busy", 6, 32'd0, 32'd12);
    @(negedge clk);
    check("ign_busy_idle", {31'd0, busy}, 32'd0);

    start_op(32'd100, 32'd200, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_hi", hi_out, 32'd0);
    check("abort_lo", lo_out, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    start_op(32'd9, 32'd9, 1'b1, 1'b0);
    wait_done("b2b_first", 1, 32'd0, 32'd81);
    start_op(32'hFFFFFFF7, 32'd9, 1'b1, 1'b0);
    wait_done("b2b_second", 1, 32'hFFFFFFFF, 32'hFFFFFFAF);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
